rpn_stack_sequencer: RTL and testbench
======================================

// Module: rpn_stack_sequencer
// PURPOSE
//  Postfix (RPN) expression sequencer for the signed arithmetic stack.
//  Accepts a token stream over valid/ready and drives stack opcodes (push/add/mul/pop).
//  Returns one result per expression, with a sticky overflow flag and an error code.
//  Sits between the host token source and the stack; it is the stack's only opcode master.
// PARAMETERS
//  DATA_WIDTH   16  operand/result width, two's complement; must match the stack.
//  STACK_DEPTH  16  stack capacity; must match the stack.
//  CNT_W        5   depth counter width, >= clog2(STACK_DEPTH+1).
// PORTS
//  clk        in   1           clock, rising edge.
//  rst        in   1           reset, asynchronous, active-low.
//  tok_valid  in   1           token present.
//  tok_ready  out  1           sequencer accepts token this cycle.
//  tok_kind   in   2           00 operand, 01 add, 10 mul, 11 end-of-expression.
//  tok_data   in   DATA_WIDTH  operand value; ignored unless kind=00.
//  stk_opcode out  3           to stack: 000 nop, 100 add, 101 mul, 110 push, 111 pop.
//  stk_din    out  DATA_WIDTH  to stack data_in.
//  stk_dout   in   DATA_WIDTH  stack data_out; valid the cycle after an op edge.
//  stk_ovf    in   1           stack overflow; valid the cycle after an add/mul edge.
//  stk_full   in   1           stack full; used as a cross-check only.
//  res_valid  out  1           result held until accepted.
//  res_ready  in   1           result consumer ready.
//  res_data   out  DATA_WIDTH  expression result; 0 when res_err!=00.
//  res_ovf    out  1           OR of stk_ovf over all add/mul in the expression.
//  res_err    out  2           00 ok, 01 underflow, 10 full, 11 leftover (depth!=1 at end).
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE, depth=0, stk_opcode=000, stk_din=0, tok_ready=0,
//   res_valid=0, res_data=0, res_ovf=0, res_err=00. Stack is reset by the same event.
//  FSM states: IDLE -> ACCEPT -> EXEC -> CHECK -> ACCEPT ... -> FINAL -> REPORT;
//   error path: DISCARD -> DRAIN -> REPORT.
//  ACCEPT: tok_ready=1. On handshake:
//   operand: depth==STACK_DEPTH -> err=10, go DISCARD; else op=110, din=tok_data.
//   add/mul: depth<2 -> err=01, go DISCARD; else op=100/101.
//   end: depth==1 -> FINAL; else err=11, go DRAIN (DISCARD is skipped; END already consumed).
//  EXEC: opcode driven for exactly one cycle. Depth update: push +1, add/mul -1.
//  CHECK: stk_opcode=000. After add/mul, res_ovf |= stk_ovf. Return to ACCEPT.
//   Throughput: one token per 3 cycles.
//  FINAL: issue one pop (111). Next cycle capture stk_dout into res_data; depth=0.
//  DISCARD: tok_ready=1. Drop tokens up to and including END; no stack ops.
//  DRAIN: pop once per 2 cycles (pop, nop) until depth==0, so the next expression starts empty.
//  REPORT: res_valid=1; res_* held stable until res_ready=1. Then clear res_ovf/err, go ACCEPT.
//   tok_ready=0 throughout.
//  IDLE: one cycle after reset release, then ACCEPT.
//  Arithmetic: wrap-around results come from the stack; the sequencer never alters data.
//  stk_full=1 while depth<STACK_DEPTH is an internal-desync assertion (sim only).
//  Reset mid-expression aborts immediately. No partial result is reported.
//  stk_opcode is registered, never combinational from tok_*.
// STRUCTURE
//  Shared include stack_ops.vh: opcode localparams (NOP/ADD/MUL/PUSH/POP),
//   token kinds, error codes. The stack and its benches use the same file.
//  Single module; depth counter and sticky flag inline. No sub-module.
// TESTING
//  Push 3, push 5, add, end -> res_data=8, res_ovf=0, res_err=00; 10 cycles token-to-end.
//  Push 32767, push 2, add, end -> res_data=-32767, res_ovf=1, res_err=00.
//  Push 300, push 200, mul, push -20, add, end -> res_ovf=1, sticky through the add.
//  Push 7, add, push 1, end -> res_err=01; tokens discarded through END;
//   one drain pop; final depth=0.
//  17 pushes, end (STACK_DEPTH=16) -> res_err=10; 16 drain pops; next "1 2 + end" gives 3.
//  Push 3, push 4, end -> res_err=11 after 2 pops; rst=0 during EXEC -> all outputs at reset values.

Source files
------------

// File: rtl/rpn_stack_sequencer_pkg.sv
// Shared opcode, token-kind and error-code encodings plus the sequencer state type.
package rpn_stack_sequencer_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TOK_OPERAND = 2'b00;
  localparam logic [1:0] TOK_ADD     = 2'b01;
  localparam logic [1:0] TOK_MUL     = 2'b10;
  localparam logic [1:0] TOK_END     = 2'b11;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_FULL      = 2'b10;
  localparam logic [1:0] ERR_LEFTOVER  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_EXEC,
    ST_CHECK,
    ST_FINAL,
    ST_CAPTURE,
    ST_DISCARD,
    ST_DRAIN,
    ST_REPORT
  } seq_state_t;

endpackage

// File: rtl/rpn_stack_sequencer.sv
// Postfix expression sequencer: turns a token stream into stack opcodes and
// reports one result per expression with sticky overflow and an error code.
module rpn_stack_sequencer
  import rpn_stack_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [1:0]            tok_kind,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic [2:0]            stk_opcode,
  output logic [DATA_WIDTH-1:0] stk_din,
  input  logic [DATA_WIDTH-1:0] stk_dout,
  input  logic                  stk_ovf,
  input  logic                  stk_full,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ovf,
  output logic [1:0]            res_err
);

  localparam logic [CNT_W-1:0] FULL_DEPTH = CNT_W'(STACK_DEPTH);

  seq_state_t       state;
  logic [CNT_W-1:0] depth;
  logic             arith;
  logic             tok_fire;

  assign tok_fire = tok_valid && tok_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      depth      <= '0;
      arith      <= 1'b0;
      stk_opcode <= OP_NOP;
      stk_din    <= '0;
      tok_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      res_err    <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          tok_ready <= 1'b1;
          state     <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (tok_fire) begin
            tok_ready <= 1'b0;
            case (tok_kind)
              TOK_OPERAND: begin
                if (depth == FULL_DEPTH) begin
                  res_err   <= ERR_FULL;
                  tok_ready <= 1'b1;
                  state     <= ST_DISCARD;
                end else begin
                  stk_opcode <= OP_PUSH;
                  stk_din    <= tok_data;
                  state      <= ST_EXEC;
                end
              end
              TOK_ADD, TOK_MUL: begin
                if (depth < CNT_W'(2)) begin
                  res_err   <= ERR_UNDERFLOW;
                  tok_ready <= 1'b1;
                  state     <= ST_DISCARD;
                end else begin
                  stk_opcode <= (tok_kind == TOK_ADD) ? OP_ADD : OP_MUL;
                  state      <= ST_EXEC;
                end
              end
              default: begin
                // END has been consumed here, so a leftover stack skips DISCARD
                if (depth == CNT_W'(1)) begin
                  stk_opcode <= OP_POP;
                  state      <= ST_FINAL;
                end else begin
                  res_err <= ERR_LEFTOVER;
                  state   <= ST_DRAIN;
                end
              end
            endcase
          end
        end
        ST_EXEC: begin
          arith      <= (stk_opcode != OP_PUSH);
          depth      <= (stk_opcode == OP_PUSH) ? depth + 1'b1 : depth - 1'b1;
          stk_opcode <= OP_NOP;
          state      <= ST_CHECK;
        end
        ST_CHECK: begin
          if (arith) res_ovf <= res_ovf | stk_ovf;
          tok_ready <= 1'b1;
          state     <= ST_ACCEPT;
        end
        ST_FINAL: begin
          stk_opcode <= OP_NOP;
          state      <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          res_data  <= stk_dout;
          depth     <= '0;
          res_valid <= 1'b1;
          state     <= ST_REPORT;
        end
        ST_DISCARD: begin
          if (tok_fire && tok_kind == TOK_END) begin
            tok_ready <= 1'b0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Alternate pop and nop so every pop gets its own settled cycle
          if (stk_opcode == OP_POP) begin
            stk_opcode <= OP_NOP;
            depth      <= depth - 1'b1;
          end else if (depth == '0) begin
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end else begin
            stk_opcode <= OP_POP;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
            res_err   <= ERR_OK;
            tok_ready <= 1'b1;
            state     <= ST_ACCEPT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  full_desync_a: assert property (@(posedge clk) disable iff (!rst)
    !(stk_full && depth < FULL_DEPTH));

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer with a behavioural signed stack model.
module tb_rpn_stack_sequencer;

  localparam logic [1:0] K_NUM = 2'b00;
  localparam logic [1:0] K_ADD = 2'b01;
  localparam logic [1:0] K_MUL = 2'b10;
  localparam logic [1:0] K_END = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [1:0]  tok_kind = 2'b00;
  logic [15:0] tok_data = '0;
  logic [2:0]  stk_opcode;
  logic [15:0] stk_din;
  logic [15:0] stk_dout;
  logic        stk_ovf;
  logic        stk_full;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_ovf;
  logic [1:0]  res_err;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int pop_count = 0;
  int last_hs = 0;

  logic [15:0] mem [0:15];
  int sp;
  int op_a, op_b, op_r;

  always #5 clk = ~clk;

  rpn_stack_sequencer dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .stk_opcode(stk_opcode), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_ovf(stk_ovf), .stk_full(stk_full),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .res_err(res_err)
  );

  // Stack model: results and overflow appear the cycle after the op edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= 0;
      stk_dout <= '0;
      stk_ovf  <= 1'b0;
    end else begin
      case (stk_opcode)
        3'b110: if (sp < 16) begin
          mem[sp] <= stk_din;
          sp      <= sp + 1;
        end
        3'b100, 3'b101: if (sp >= 2) begin
          op_a = int'($signed(mem[sp-2]));
          op_b = int'($signed(mem[sp-1]));
          op_r = (stk_opcode == 3'b100) ? op_a + op_b : op_a * op_b;
          mem[sp-2] <= op_r[15:0];
          stk_dout  <= op_r[15:0];
          stk_ovf   <= (op_r > 32767) || (op_r < -32768);
          sp        <= sp - 1;
        end
        3'b111: if (sp > 0) begin
          stk_dout <= mem[sp-1];
          sp       <= sp - 1;
        end
        default: ;
      endcase
    end
  end

  assign stk_full = (sp == 16);

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst && stk_opcode == 3'b111) pop_count <= pop_count + 1;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] kind, input int data);
    int waited;
    tok_kind  = kind;
    tok_data  = 16'(data);
    tok_valid = 1'b1;
    waited = 0;
    while (!tok_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!tok_ready) begin
      checkOutput("tok_ready_timeout", int'(tok_ready), 1);
      tok_valid = 1'b0;
      return;
    end
    last_hs = cycle;
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic collectResult(output int data, output int ovf, output int err);
    int waited;
    waited = 0;
    while (!res_valid && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!res_valid) begin
      checkOutput("res_valid_timeout", int'(res_valid), 1);
      data = -1; ovf = -1; err = -1;
      return;
    end
    data = int'($signed(res_data));
    ovf  = int'(res_ovf);
    err  = int'(res_err);
    @(posedge clk); #1;
    checkOutput("res_valid_held", int'(res_valid), 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("res_valid_cleared", int'(res_valid), 0);
  endtask

  initial begin
    int d, o, e, first_hs, pops0, waited;

    #2;
    checkOutput("rst_opcode", int'(stk_opcode), 0);
    checkOutput("rst_tok_ready", int'(tok_ready), 0);
    checkOutput("rst_res_valid", int'(res_valid), 0);
    checkOutput("rst_res_err", int'(res_err), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 3 5 + end
    applyStimulus(K_NUM, 3); first_hs = last_hs;
    applyStimulus(K_NUM, 5);
    applyStimulus(K_ADD, 0);
    applyStimulus(K_END, 0);
    checkOutput("t1_token_to_end_cycles", last_hs - first_hs + 1, 10);
    collectResult(d, o, e);
    checkOutput("t1_data", d, 8);
    checkOutput("t1_ovf", o, 0);
    checkOutput("t1_err", e, 0);

    // 32767 2 + end: wraps
    applyStimulus(K_NUM, 32767);
    applyStimulus(K_NUM, 2);
    applyStimulus(K_ADD, 0);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t2_data", d, -32767);
    checkOutput("t2_ovf", o, 1);
    checkOutput("t2_err", e, 0);

    // 300 200 * -20 + end: ovf sticky through the add
    applyStimulus(K_NUM, 300);
    applyStimulus(K_NUM, 200);
    applyStimulus(K_MUL, 0);
    applyStimulus(K_NUM, -20);
    applyStimulus(K_ADD, 0);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t3_data", d, -5556);
    checkOutput("t3_ovf", o, 1);
    checkOutput("t3_err", e, 0);

    // 7 + 1 end: underflow, rest discarded, one drain pop
    pops0 = pop_count;
    applyStimulus(K_NUM, 7);
    applyStimulus(K_ADD, 0);
    applyStimulus(K_NUM, 1);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t4_err", e, 1);
    checkOutput("t4_data", d, 0);
    checkOutput("t4_pops", pop_count - pops0, 1);
    checkOutput("t4_stack_depth", sp, 0);

    // 17 pushes then end: full, 16 drain pops
    pops0 = pop_count;
    for (int i = 1; i <= 17; i++) applyStimulus(K_NUM, i);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t5_err", e, 2);
    checkOutput("t5_data", d, 0);
    checkOutput("t5_pops", pop_count - pops0, 16);
    checkOutput("t5_stack_depth", sp, 0);

    applyStimulus(K_NUM, 1);
    applyStimulus(K_NUM, 2);
    applyStimulus(K_ADD, 0);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t5b_data", d, 3);
    checkOutput("t5b_ovf", o, 0);
    checkOutput("t5b_err", e, 0);

    // 3 4 end: leftover, two drain pops
    pops0 = pop_count;
    applyStimulus(K_NUM, 3);
    applyStimulus(K_NUM, 4);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t6_err", e, 3);
    checkOutput("t6_data", d, 0);
    checkOutput("t6_pops", pop_count - pops0, 2);

    // Reset asserted while a push is in EXEC
    applyStimulus(K_NUM, 9);
    applyStimulus(K_NUM, 11);
    tok_kind = K_NUM; tok_data = 16'd6; tok_valid = 1'b1;
    waited = 0;
    while (stk_opcode != 3'b110 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("t7_reached_exec", int'(stk_opcode), 6);
    rst = 1'b0;
    #1;
    tok_valid = 1'b0;
    checkOutput("t7_opcode", int'(stk_opcode), 0);
    checkOutput("t7_din", int'(stk_din), 0);
    checkOutput("t7_tok_ready", int'(tok_ready), 0);
    checkOutput("t7_res_valid", int'(res_valid), 0);
    checkOutput("t7_res_data", int'(res_data), 0);
    checkOutput("t7_res_ovf", int'(res_ovf), 0);
    checkOutput("t7_res_err", int'(res_err), 0);
    @(negedge clk); rst = 1'b1;

    // Fresh expression after the aborted one
    applyStimulus(K_NUM, 4);
    applyStimulus(K_NUM, 6);
    applyStimulus(K_MUL, 0);
    applyStimulus(K_END, 0);
    collectResult(d, o, e);
    checkOutput("t8_data", d, 24);
    checkOutput("t8_err", e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
